farm_bus_transmitter: RTL
=========================

Name: farm_bus_transmitter

Overview:
Host-side transmitter for the growth-monitor bus. It drives the 8-bit data byte plus the mode, vsync, href and sensor-select lines that the monitor tile samples each clock. In sensor mode it round-robins four held sensor samples. On request it emits one camera frame of pixels with vsync/href framing, then a blanking tail so the monitor can run its frame analysis.

Parameters:
LINE_PIXELS, 16, pixels per line (1..255)
FRAME_LINES, 8, lines per frame (1..255)
VSYNC_CYCLES, 2, cycles vsync is held high at frame start (1..15)
HBLANK_CYCLES, 2, href-low cycles between lines (1..15)
TAIL_CYCLES, 4, mode=1, vsync=0, href=0 cycles after last line (1..15)
SENSOR_REPEAT, 4, consecutive cycles each sensor channel is presented (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
sens_wr  in  1  write strobe for a sample register
sens_addr  in  2  channel: 0 soil, 1 temp, 2 humid, 3 light
sens_data  in  8  sample value
scan_en  in  1  enable sensor round-robin while idle
frame_req  in  1  request one camera frame (level or pulse; latched)
pix_valid  in  1  upstream pixel available
pix_data  in  8  RGB332 pixel
pix_ready  out  1  pixel accepted this cycle when pix_valid and pix_ready are both high
pat_en  in  1  select internal test pattern (only used with TEST_PATTERN_EN)
bus_data  out  8  byte to monitor ui_in
bus_sel  out  2  to monitor uio_in[1:0]
bus_href  out  1  to monitor uio_in[5]
bus_vsync  out  1  to monitor uio_in[6]
bus_mode  out  1  to monitor uio_in[7]; 0 = sensor, 1 = camera
busy  out  1  high in any camera-mode state
frame_done  out  1  one-cycle pulse on last TAIL cycle
underrun  out  1  one-cycle pulse per LINE cycle with no pixel available

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All bus outputs, pix_ready, busy, frame_done and underrun go to 0.
  - Sample registers clear to 0. State goes to IDLE. Pending request clears.
  - Reset mid-frame aborts immediately; there is no tail.
- Registered outputs: all bus_* outputs update on the edge that enters or advances a state. Data presented on bus_data with href=1 is the pixel accepted on the previous edge (1-cycle latency).
- sens_wr writes a sample register in any state. A write to the channel currently on the bus shows on bus_data the next cycle.
- frame_req sets a pending flag. The flag clears on entry to VSYNC. Requests made while busy are latched and give exactly one further frame.
- States:
  - IDLE: mode=0, href=0, vsync=0, data=0, sel holds.
    - Pending -> VSYNC.
    - Else scan_en -> SENSOR with sel=0.
  - SENSOR: mode=0, sel=ch, data=sample[ch].
    - Each channel is presented SENSOR_REPEAT cycles, then ch increments (wraps 3 -> 0).
    - At a slot end: pending -> VSYNC; else !scan_en -> IDLE.
    - No mid-slot exit except reset.
  - VSYNC: mode=1, vsync=1, href=0, data=0, held VSYNC_CYCLES cycles.
    - Column and line counters clear, then -> LINE.
  - LINE: mode=1, pix_ready=1.
    - On a handshake: drive href=1 and data=pixel next cycle; column increments.
    - No pix_valid: href=0, data holds, underrun pulses, column holds.
    - After handshake number LINE_PIXELS: line increments. Last line -> TAIL, else -> HBLANK. pix_ready drops the same edge.
  - HBLANK: mode=1, href=0, HBLANK_CYCLES cycles -> LINE.
  - TAIL: mode=1, href=0, vsync=0, TAIL_CYCLES cycles.
    - frame_done pulses on the last cycle.
    - Next: pending -> VSYNC, else scan_en -> SENSOR ch=0, else IDLE.
- busy = 1 in VSYNC, LINE, HBLANK and TAIL.
- Counters: column and line are 8-bit; the state-hold counter is 4-bit. Compares are equality against parameters, so there is no wrap inside a frame.
- pix_ready is 0 outside LINE. Upstream must hold pix_valid and pix_data stable until accepted.

Optional Feature:
TEST_PATTERN_EN
- Defined:
  - With pat_en=1 at VSYNC entry (sampled for the whole frame), pixels come from an internal generator:
    - column < LINE_PIXELS/2 -> 8'hF0 (yellow).
    - Otherwise -> 8'h1C (green).
  - The generator is always valid; pix_ready stays 0 and underrun never fires.
- Undefined: pat_en is ignored and no generator logic exists.

Test Plan:
- Write samples 150/120/130/200 to ch0..3, scan_en=1 -> bus_sel sequence 0,0,0,0,1,1,1,1,2,...; bus_data matches the channel's sample; mode=0.
- frame_req pulse mid-slot on ch1 -> ch1 completes its 4 cycles, then vsync=1 for 2 cycles, then 8 lines of 16 href=1 pixels separated by 2 href-low cycles, then 4 tail cycles, frame_done once, return to SENSOR ch0.
- pix_valid deasserted 3 cycles mid-line -> 3 underrun pulses, href=0 for those cycles, still exactly 16 pixels in the line, in order.
- rst_n=0 during line 3 -> next cycle all outputs 0, state IDLE; a later frame_req yields a full fresh frame.
- frame_req asserted during TAIL -> VSYNC immediately follows TAIL, no SENSOR cycles in between.
- TEST_PATTERN_EN defined, pat_en=1 -> each line has 8×8'hF0 then 8×8'h1C, pix_ready=0 throughout.

Source files
------------

// File: rtl/farm_bus_transmitter.sv
// Growth-monitor bus transmitter: sensor round-robin plus one camera frame per request.
// Optional build macro TEST_PATTERN_EN adds an internal yellow/green test-pattern source.
module farm_bus_transmitter #(
    parameter int LINE_PIXELS   = 16,
    parameter int FRAME_LINES   = 8,
    parameter int VSYNC_CYCLES  = 2,
    parameter int HBLANK_CYCLES = 2,
    parameter int TAIL_CYCLES   = 4,
    parameter int SENSOR_REPEAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sens_wr,
    input  logic [1:0] sens_addr,
    input  logic [7:0] sens_data,
    input  logic       scan_en,
    input  logic       frame_req,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    input  logic       pat_en,
    output logic [7:0] bus_data,
    output logic [1:0] bus_sel,
    output logic       bus_href,
    output logic       bus_vsync,
    output logic       bus_mode,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {S_IDLE, S_SENSOR, S_VSYNC, S_LINE, S_HBLANK, S_TAIL} state_t;

    localparam logic [7:0] LAST_COL  = 8'(LINE_PIXELS - 1);
    localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);
    localparam logic [3:0] LAST_VS   = 4'(VSYNC_CYCLES - 1);
    localparam logic [3:0] LAST_HB   = 4'(HBLANK_CYCLES - 1);
    localparam logic [3:0] LAST_TL   = 4'(TAIL_CYCLES - 1);
    localparam logic [3:0] LAST_REP  = 4'(SENSOR_REPEAT - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      col_q, col_d;
    logic [7:0]      line_q, line_d;
    logic [1:0]      ch_q, ch_d;
    logic            pend_q, pend_d;
    logic [3:0][7:0] smp_q, smp_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      sel_q, sel_d;
    logic            href_q, href_d;
    logic            vsync_q, vsync_d;
    logic            mode_q, mode_d;
    logic            enter_vs;
    logic            use_pat;
    logic [7:0]      src_pix;
    logic            hs;

`ifdef TEST_PATTERN_EN
    localparam logic [7:0] HALF_COL = 8'(LINE_PIXELS / 2);
    logic pat_q, pat_d;

    // Pattern select is frozen at VSYNC entry so a frame never mixes sources.
    always_comb begin
        pat_d = pat_q;
        if (enter_vs) pat_d = pat_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pat_q <= 1'b0;
        else        pat_q <= pat_d;
    end

    assign use_pat = pat_q;
    assign src_pix = use_pat ? ((col_q < HALF_COL) ? 8'hF0 : 8'h1C) : pix_data;
`else
    logic unused_pat;
    assign unused_pat = pat_en;
    assign use_pat    = 1'b0;
    assign src_pix    = pix_data;
`endif

    assign hs = (state_q == S_LINE) && (use_pat || pix_valid);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        line_d  = line_q;
        ch_d    = ch_q;
        smp_d   = smp_q;
        if (sens_wr) smp_d[sens_addr] = sens_data;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                end else if (scan_en) begin
                    state_d = S_SENSOR;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_SENSOR: begin
                if (cnt_q == LAST_REP) begin
                    cnt_d = '0;
                    ch_d  = ch_q + 2'd1;
                    if (pend_q)        state_d = S_VSYNC;
                    else if (!scan_en) state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_VSYNC: begin
                if (cnt_q == LAST_VS) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    col_d   = '0;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LINE: begin
                if (hs) begin
                    col_d = col_q + 8'd1;
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        line_d  = line_q + 8'd1;
                        cnt_d   = '0;
                        state_d = (line_q == LAST_LINE) ? S_TAIL : S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == LAST_HB) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_TAIL: begin
                if (cnt_q == LAST_TL) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        state_d = S_VSYNC;
                    end else if (scan_en) begin
                        state_d = S_SENSOR;
                        ch_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request arriving on the entry edge itself is a new request and survives.
        enter_vs = (state_d == S_VSYNC) && (state_q != S_VSYNC);
        pend_d   = frame_req | (pend_q & ~enter_vs);

        data_d  = data_q;
        sel_d   = sel_q;
        href_d  = 1'b0;
        vsync_d = 1'b0;
        mode_d  = 1'b1;
        case (state_d)
            S_IDLE: begin
                mode_d = 1'b0;
                data_d = '0;
            end
            S_SENSOR: begin
                mode_d = 1'b0;
                sel_d  = ch_d;
                data_d = smp_d[ch_d];
            end
            S_VSYNC: begin
                vsync_d = 1'b1;
                data_d  = '0;
            end
            default: ;
        endcase
        if (hs) begin
            href_d = 1'b1;
            data_d = src_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            line_q  <= '0;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            smp_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            line_q  <= line_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            smp_q   <= smp_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            mode_q  <= mode_d;
        end
    end

    assign bus_data   = data_q;
    assign bus_sel    = sel_q;
    assign bus_href   = href_q;
    assign bus_vsync  = vsync_q;
    assign bus_mode   = mode_q;
    assign busy       = state_q inside {S_VSYNC, S_LINE, S_HBLANK, S_TAIL};
    assign pix_ready  = (state_q == S_LINE) && !use_pat;
    assign underrun   = (state_q == S_LINE) && !use_pat && !pix_valid;
    assign frame_done = (state_q == S_TAIL) && (cnt_q == LAST_TL);
endmodule
